// File: rtl/tdm_demux3.sv
// -----------------------------------------------------------------------------
// tdm_demux3
//
// Receiving end of the three-input select path. A registered 1-to-3
// demultiplexer that routes one data stream onto three channel registers
// u / v / w, in one of two modes:
//   - manual (tdm_en = 0): every valid beat goes to one channel, chosen by
//     s1 (highest priority) -> w, else s0 -> v, else u.
//   - TDM    (tdm_en = 1): beats arrive as frames u,v,w with in_sync on the
//     u beat. A HUNT/RUN framer with a slot counter collects u and v in
//     shadow registers and commits all three channels on the w beat.
//
// Handshake: in_valid qualifies a beat. There is no backpressure; a cycle
// with in_valid = 0 is a stall where framer state and shadows hold.
// out_stb / sync_err are one-cycle pulses that follow the edge which
// sampled the beat.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   tdm_en    : 1 = TDM frame mode, 0 = manual select mode
//   s0, s1    : manual channel select (s1 overrides s0)
//   in_valid  : input beat present
//   in_sync   : beat is slot 0 of a frame (TDM mode only)
//   in_data   : input beat
//   u, v, w   : channel registers
//   out_stb   : per-channel write strobe (bit0 = u, bit1 = v, bit2 = w)
//   locked    : framer is in RUN (doubles as the FSM state observation)
//   sync_err  : one-cycle pulse on a frame-alignment error
// -----------------------------------------------------------------------------
module tdm_demux3 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tdm_en,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] u,
    output logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] w,
    output logic [2:0]       out_stb,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] SLOT_U = 2'd0;
    localparam logic [1:0] SLOT_V = 2'd1;
    localparam logic [1:0] SLOT_W = 2'd2;

    logic [0:0]       state;
    logic [0:0]       state_d;
    logic [1:0]       slot;
    logic [1:0]       slot_d;
    logic [WIDTH-1:0] shadow_u;
    logic [WIDTH-1:0] shadow_v;

    // Per-beat decisions made by the next-state logic.
    logic       load_su;   // capture in_data into shadow u
    logic       load_sv;   // capture in_data into shadow v
    logic       commit;    // write u/v/w from shadows + current beat
    logic       err;       // frame-alignment error on this beat
    logic [2:0] man_sel;   // one-hot manual channel select

    // locked is a direct view of the registered FSM state.
    assign locked = (state == ST_RUN);

    always_comb begin
        state_d = state;
        slot_d  = slot;
        load_su = 1'b0;
        load_sv = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        man_sel = 3'b000;

        if (!tdm_en) begin
            // Manual mode parks the framer; a partial frame is dropped
            // silently when tdm_en falls mid-frame.
            state_d = ST_HUNT;
            slot_d  = SLOT_U;
            if (in_valid) begin
                if (s1)      man_sel = 3'b100;
                else if (s0) man_sel = 3'b010;
                else         man_sel = 3'b001;
            end
        end else if (in_valid) begin
            if (state == ST_HUNT) begin
                // Beats without sync are discarded until a frame start shows up.
                if (in_sync) begin
                    load_su = 1'b1;
                    state_d = ST_RUN;
                    slot_d  = SLOT_V;
                end
            end else begin
                case (slot)
                    SLOT_U: begin
                        if (in_sync) begin
                            load_su = 1'b1;
                            slot_d  = SLOT_V;
                        end else begin
                            // Lost alignment with no new frame start: re-hunt.
                            err     = 1'b1;
                            state_d = ST_HUNT;
                            slot_d  = SLOT_U;
                        end
                    end
                    SLOT_V, SLOT_W: begin
                        if (in_sync) begin
                            // Early frame start: drop the partial frame and
                            // treat this beat as the new slot 0.
                            err     = 1'b1;
                            load_su = 1'b1;
                            slot_d  = SLOT_V;
                        end else if (slot == SLOT_V) begin
                            load_sv = 1'b1;
                            slot_d  = SLOT_W;
                        end else begin
                            commit  = 1'b1;
                            slot_d  = SLOT_U;
                        end
                    end
                    default: begin
                        // Unreachable slot code: recover through HUNT.
                        state_d = ST_HUNT;
                        slot_d  = SLOT_U;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HUNT;
            slot     <= SLOT_U;
            shadow_u <= '0;
            shadow_v <= '0;
            u        <= '0;
            v        <= '0;
            w        <= '0;
            out_stb  <= 3'b000;
            sync_err <= 1'b0;
        end else begin
            state    <= state_d;
            slot     <= slot_d;
            sync_err <= err;

            if (load_su) shadow_u <= in_data;
            if (load_sv) shadow_v <= in_data;

            if (commit) begin
                u       <= shadow_u;
                v       <= shadow_v;
                w       <= in_data;
                out_stb <= 3'b111;
            end else begin
                if (man_sel[0]) u <= in_data;
                if (man_sel[1]) v <= in_data;
                if (man_sel[2]) w <= in_data;
                out_stb <= man_sel;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux3.sv
module tb_tdm_demux3;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         tdm_en;
  logic         s0;
  logic         s1;
  logic         in_valid;
  logic         in_sync;
  logic [W-1:0] in_data;
  logic [W-1:0] u;
  logic [W-1:0] v;
  logic [W-1:0] w;
  logic [2:0]   out_stb;
  logic         locked;
  logic         sync_err;

  always #5 clk = ~clk;

  tdm_demux3 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .tdm_en   (tdm_en),
    .s0       (s0),
    .s1       (s1),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_data  (in_data),
    .u        (u),
    .v        (v),
    .w        (w),
    .out_stb  (out_stb),
    .locked   (locked),
    .sync_err (sync_err)
  );

  // ---------------------------------------------------------------------------
  // scoreboard: record = {out_stb, sync_err, u, v, w}
  // ---------------------------------------------------------------------------
  localparam int RW = 3 + 1 + 3 * W;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_rec;
  logic [W-1:0]  cu = '0;
  logic [W-1:0]  cv = '0;
  logic [W-1:0]  cw = '0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_man(input logic [2:0] stb, input logic [W-1:0] d);
    if (stb[0]) cu = d;
    if (stb[1]) cv = d;
    if (stb[2]) cw = d;
    exp_q.push_back({stb, 1'b0, cu, cv, cw});
  endtask

  task automatic exp_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    cu = a;
    cv = b;
    cw = c;
    exp_q.push_back({3'b111, 1'b0, cu, cv, cw});
  endtask

  task automatic exp_sync_err();
    exp_q.push_back({3'b000, 1'b1, cu, cv, cw});
  endtask

  // Every strobe or error pulse must match the next expected record.
  always @(negedge clk) begin
    if (out_stb != 3'b000 || sync_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {28'd0, out_stb, sync_err}, 32'd0);
      end else begin
        exp_rec = exp_q.pop_front();
        check("event", {4'd0, out_stb, sync_err, u, v, w}, {4'd0, exp_rec});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // driver tasks (called at #1 after a rising edge, return at #1 after the next)
  // ---------------------------------------------------------------------------
  task automatic beat(input logic [W-1:0] d, input logic sync, input logic [1:0] sel,
                      input logic [2:0] stb);
    in_valid = 1'b1;
    in_sync  = sync;
    in_data  = d;
    s1       = sel[1];
    s0       = sel[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    check("stb_latency", {29'd0, out_stb}, {29'd0, stb});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_uvw"}, {8'd0, u, v, w}, 32'd0);
    check({tag, "_stb"}, {29'd0, out_stb}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
  endtask

  task automatic tdm_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    beat(a, 1'b1, 2'b00, 3'b000);
    check("locked_after_sync", {31'd0, locked}, 32'd1);
    beat(b, 1'b0, 2'b00, 3'b000);
    exp_frame(a, b, c);
    beat(c, 1'b0, 2'b00, 3'b111);
    check("locked_after_frame", {31'd0, locked}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    tdm_en   = 1'b0;
    s0       = 1'b0;
    s1       = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    // manual mode, s1 over s0 priority
    exp_man(3'b001, 8'h11); beat(8'h11, 1'b0, 2'b00, 3'b001);
    exp_man(3'b010, 8'h22); beat(8'h22, 1'b0, 2'b01, 3'b010);
    exp_man(3'b100, 8'h33); beat(8'h33, 1'b0, 2'b10, 3'b100);
    exp_man(3'b100, 8'h44); beat(8'h44, 1'b0, 2'b11, 3'b100);
    check("manual_locked", {31'd0, locked}, 32'd0);
    idle(1);

    // TDM clean back-to-back frames
    tdm_en = 1'b1;
    tdm_frame(8'hA1, 8'hB2, 8'hC3);
    tdm_frame(8'h01, 8'h02, 8'h03);

    // same frame with stalls inside
    beat(8'hA1, 1'b1, 2'b00, 3'b000);
    idle(2);
    check("stall_locked", {31'd0, locked}, 32'd1);
    beat(8'hB2, 1'b0, 2'b00, 3'b000);
    idle(1);
    exp_frame(8'hA1, 8'hB2, 8'hC3);
    beat(8'hC3, 1'b0, 2'b00, 3'b111);

    // early sync at slot 1: error, restart frame from that beat
    beat(8'h10, 1'b1, 2'b00, 3'b000);
    exp_sync_err();
    beat(8'h20, 1'b1, 2'b00, 3'b000);
    check("early_sync_locked", {31'd0, locked}, 32'd1);
    beat(8'h30, 1'b0, 2'b00, 3'b000);
    exp_frame(8'h20, 8'h30, 8'h40);
    beat(8'h40, 1'b0, 2'b00, 3'b111);

    // missing sync at slot 0: error and back to HUNT
    exp_sync_err();
    beat(8'h77, 1'b0, 2'b00, 3'b000);
    check("missing_sync_locked", {31'd0, locked}, 32'd0);
    idle(1);

    // HUNT discards unsynced beats after reset
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    cu = '0; cv = '0; cw = '0;
    check_reset_state("reset2");
    beat(8'h55, 1'b0, 2'b00, 3'b000);
    beat(8'h66, 1'b0, 2'b00, 3'b000);
    check("hunt_locked", {31'd0, locked}, 32'd0);
    check("hunt_uvw", {8'd0, u, v, w}, 32'd0);

    // reset mid-frame wins over a slot-2 beat in the same cycle
    tdm_frame(8'h91, 8'h92, 8'h93);
    beat(8'h81, 1'b1, 2'b00, 3'b000);
    beat(8'h82, 1'b0, 2'b00, 3'b000);
    rst = 1'b1;
    beat(8'h84, 1'b0, 2'b00, 3'b000);
    rst = 1'b0;
    cu = '0; cv = '0; cw = '0;
    check_reset_state("reset_mid");
    beat(8'h85, 1'b0, 2'b00, 3'b000);
    check("post_reset_hunt", {31'd0, locked}, 32'd0);

    // tdm_en drop mid-frame: silent drop, then manual works
    tdm_frame(8'hE1, 8'hE2, 8'hE3);
    beat(8'hF1, 1'b1, 2'b00, 3'b000);
    beat(8'hF2, 1'b0, 2'b00, 3'b000);
    tdm_en = 1'b0;
    idle(1);
    check("mode_drop_locked", {31'd0, locked}, 32'd0);
    check("mode_drop_err", {31'd0, sync_err}, 32'd0);
    check("mode_drop_uvw", {8'd0, u, v, w}, {8'd0, 8'hE1, 8'hE2, 8'hE3});
    tdm_en = 1'b1;
    beat(8'hF3, 1'b0, 2'b00, 3'b000);
    tdm_en = 1'b0;
    exp_man(3'b010, 8'h5A);
    beat(8'h5A, 1'b0, 2'b01, 3'b010);

    // random manual beats
    for (int i = 0; i < 20; i++) begin
      logic [1:0]   sel;
      logic [W-1:0] d;
      logic [2:0]   stb;
      sel = 2'($urandom_range(0, 3));
      d   = W'($urandom_range(0, 255));
      stb = sel[1] ? 3'b100 : (sel[0] ? 3'b010 : 3'b001);
      exp_man(stb, d);
      beat(d, 1'($urandom_range(0, 1)), sel, stb);
    end

    idle(3);
    check("queue_left", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
